seg7_count_display: RTL
=======================

# seg7_count_display

Displays the 8-bit value produced by the lab counter, range 0–255, as three decimal digits on a multiplexed 7-segment display. The block sits directly downstream of the counter: its `value` input takes the counter's count output, and its `carry_in` input takes the counter's carry flag. The binary value is converted to BCD by a sequential shift-add-3 engine. A refresh divider then scans the three digits onto a shared segment bus.

## Interface
- `CLK_HZ`, default 50_000_000: frequency of `clk_in` in Hz.
- `SCAN_HZ`, default 1_000: digit switch rate in Hz.
  - `DIV = CLK_HZ/SCAN_HZ`; `DIV ≥ 2` is required, and elaboration fails otherwise.
- `ACTIVE_LOW`, default 1: sets the polarity of the segment and anode outputs.
  - 1 means a lit segment or enabled digit is driven as 0.
- `clk_in`  in  1  the single clock; all logic is on the rising edge.
- `rst_in`  in  1  reset, synchronous and active-high.
- `value`  in  8  binary count to display.
- `carry_in`  in  1  counter carry flag, lights the decimal point of the ones digit.
- `seg_out`  out  7  segments a..g, with bit 0 = a.
- `dp_out`  out  1  decimal point.
- `an_out`  out  3  digit enables: bit 0 = ones, bit 1 = tens, bit 2 = hundreds.

## Operation
- **Reset** (`rst_in`=1 at an edge):
  - Segments, dp and all anodes go to the off level.
  - The BCD register goes to 000 and the captured value to 0.
  - The FSM goes to IDLE with the `force` flag set.
  - The digit index goes to 0 and the refresh counter to 0.
  - A reset asserted mid-conversion aborts the conversion; the BCD register is not updated.
- **Converter FSM**, states IDLE → SHIFT → DONE → IDLE.
  - **IDLE:** if `force`=1 or `value` ≠ captured value, capture `value` into the shift register and the captured register, clear `force`, load bit counter = 7, and go to SHIFT.
  - **SHIFT** (8 cycles):
    - First, add 3 to each BCD nibble that is ≥5.
    - Then shift the {bcd, bin} register left by 1.
    - Exit to DONE after the bit counter reaches 0.
  - **DONE:** copy the 12-bit BCD result to the display register, then go to IDLE.
  - Changes to `value` while in SHIFT or DONE are ignored. They are picked up by the IDLE comparison afterwards.
- **Scan:**
  - The refresh counter counts 0..DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→0.
- **Output registers**, updated every cycle from the current index and the display register:
  - Drive the segment pattern of the selected nibble.
  - Assert exactly one anode.
  - `dp_out` is lit only when index = 0 and `carry_in` = 1.
- **Blanking and patterns:**
  - A blanked digit keeps its anode asserted but drives the blank pattern.
  - Nibble values above 9 cannot occur; they are mapped to blank.

## Timing
- Conversion latency from the capture edge E0:
  - Shift edges are E1..E8.
  - The display register is written at E9.
  - `seg_out` shows the new digit at E10, provided that digit is selected.
- Minimum spacing between successive captures is 10 cycles.
- The first conversion after reset captures at the first edge with `rst_in`=0.
- Each digit is held for exactly DIV cycles. The full frame is 3·DIV cycles.
- `carry_in` reaches `dp_out` with 1 cycle of latency while the ones digit is selected.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Hundreds are blank when 0.
  - Tens are blank when both hundreds and tens are 0.
  - Ones are always shown.
- Not defined: all three digits are always shown, zero-padded, e.g. `007`.

## Structure
- Shared package `seg7_pkg` holds:
  - the segment patterns for 0–9 and blank, in active-high form; polarity is applied at the output;
  - the converter state encoding (IDLE, SHIFT, DONE);
  - the digit index width.
- Sub-module `bin8_to_bcd` contains the sequential converter: start/busy/done handshake, 8-bit in, 12-bit out.
- The top level contains the refresh divider, digit index, blanking, and output registers.

## Test plan
Run the scan tests with `DIV`=4.
- **Reset and first conversion:** hold `rst_in`=1 for 3 cycles with `value`=0, then release.
  - During reset, outputs are off: `seg_out`=7'h7F and `an_out`=3'b111 (active low).
  - After E10, the ones digit shows "0" (7'h40).
- **Conversion values:** `value`=255, then 100.
  - BCD register = 0x255 at E9, then 0x100 on the next conversion.
  - With `SEG7_LZB_EN`, the hundreds digit shows "1", not blank.
- **Mid-conversion change:** `value`=12, then change to 200 at E4.
  - First result 0x012 at E9.
  - Recapture in IDLE at E10; result 0x200 at E19.
- **Reset mid-conversion:** start converting 99 from a displayed 0x042, assert reset at E5.
  - BCD register = 000 after reset; it never holds 0x099 from the aborted run.
- **Scan order:** `an_out` cycles ones→tens→hundreds, each active for exactly 4 cycles.
  - `dp_out` is lit only in the ones slot with `carry_in`=1.
- **Blanking:** `value`=7.
  - With `SEG7_LZB_EN`: the tens and hundreds slots show the blank pattern.
  - Without it: they show "0".

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//
// Shared definitions for the 7-segment count display:
//   - DIGIT_IDX_W / NUM_DIGITS : width of the scan digit index and digit count
//   - conv_state_t             : state encoding of the binary-to-BCD converter
//   - SEG_BLANK                : all-segments-off pattern (active-high form)
//   - seg_pattern()            : nibble to segment pattern, bit 0 = segment a,
//                                active-high; polarity is applied at the output
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS  = 3;
    localparam int DIGIT_IDX_W = 2;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment pattern for one BCD digit. Values above 9 never come
    // out of the converter, but if they did they are shown as blank rather
    // than as garbage.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble,
                                               input logic       blank);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    pattern = 7'h3F;
                4'd1:    pattern = 7'h06;
                4'd2:    pattern = 7'h5B;
                4'd3:    pattern = 7'h4F;
                4'd4:    pattern = 7'h66;
                4'd5:    pattern = 7'h6D;
                4'd6:    pattern = 7'h7D;
                4'd7:    pattern = 7'h07;
                4'd8:    pattern = 7'h7F;
                4'd9:    pattern = 7'h6F;
                default: pattern = SEG_BLANK;
            endcase
        end
        return pattern;
    endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// -----------------------------------------------------------------------------
// bin8_to_bcd
//
// Sequential shift-add-3 (double dabble) converter, 8-bit binary to three BCD
// digits. One conversion takes 10 cycles from the start edge: the capture
// edge, eight shift edges and one DONE cycle during which the result is valid.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, aborts a conversion in flight
//   start  in   request a conversion; only honoured while idle
//   bin    in   8-bit binary value, sampled on the accepted start edge
//   busy   out  high while shifting or in DONE (start is ignored)
//   done   out  high for the single DONE cycle; bcd is valid then
//   bcd    out  12-bit BCD result {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bin8_to_bcd
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state;
    conv_state_t state_next;
    logic [19:0] shift_reg;
    logic [19:0] shift_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_cnt_next;
    logic [11:0] adjusted;

    // Upper 12 bits of the working register are the BCD digits under
    // construction; the lower 8 bits are the remaining binary input.
    assign bcd  = shift_reg[19:8];
    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_DONE);

    // Add-3 correction: any digit of 5 or more would overflow past 9 once
    // doubled by the following shift, so it is pre-biased here.
    always_comb begin
        adjusted = shift_reg[19:8];
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (shift_reg[8 + 4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = shift_reg[8 + 4*d +: 4] + 4'd3;
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CONV_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
        end
    end

    // Next-state logic. The bit counter is loaded with 7 and the exit to DONE
    // happens on the shift where it is already 0, giving exactly 8 shifts.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        case (state)
            CONV_IDLE: begin
                if (start) begin
                    shift_next   = {12'd0, bin};
                    bit_cnt_next = 3'd7;
                    state_next   = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                shift_next   = {adjusted[10:0], shift_reg[7:0], 1'b0};
                bit_cnt_next = bit_cnt - 3'd1;
                if (bit_cnt == 3'd0) begin
                    state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                state_next = CONV_IDLE;
            end
            default: begin
                state_next = CONV_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seg7_count_display.sv
// -----------------------------------------------------------------------------
// seg7_count_display
//
// Shows the 8-bit lab counter value (0..255) as three decimal digits on a
// multiplexed 7-segment display. A change in value (or the first cycle after
// reset) triggers a BCD conversion; a refresh divider scans the digits.
//
// Parameters:
//   CLK_HZ      clock frequency in Hz
//   SCAN_HZ     digit switch rate in Hz; DIV = CLK_HZ/SCAN_HZ must be >= 2
//   ACTIVE_LOW  1: lit segment / enabled digit driven as 0
//
// Ports:
//   clk_in    in   clock, rising edge
//   rst_in    in   synchronous active-high reset
//   value     in   8-bit count to display
//   carry_in  in   counter carry, lights the ones-digit decimal point
//   seg_out   out  segments a..g, bit 0 = a
//   dp_out    out  decimal point
//   an_out    out  digit enables, bit 0 = ones, 1 = tens, 2 = hundreds
//
// Build option: define SEG7_LZB_EN for leading-zero blanking of the hundreds
// and tens digits; otherwise all digits are shown zero-padded.
// -----------------------------------------------------------------------------
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] value,
    input  logic       carry_in,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [2:0] an_out
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic LOW = (ACTIVE_LOW != 0);
    localparam logic [DIGIT_IDX_W-1:0] IDX_LAST = DIGIT_IDX_W'(NUM_DIGITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("seg7_count_display: CLK_HZ/SCAN_HZ must be at least 2");
        end
    endgenerate

    logic [7:0]             captured;
    logic                   force_conv;
    logic                   conv_start;
    logic                   conv_busy;
    logic                   conv_done;
    logic [11:0]            conv_bcd;
    logic [11:0]            display_bcd;
    logic [CNT_W-1:0]       refresh_cnt;
    logic [DIGIT_IDX_W-1:0] digit_idx;
    logic [3:0]             nibble;
    logic                   blank;
    logic [2:0]             an_sel;
    logic [6:0]             seg_hi;

    // A new conversion is requested only while the converter is idle, so
    // value changes during a conversion are picked up once it finishes.
    assign conv_start = !conv_busy && (force_conv || (value != captured));

    bin8_to_bcd u_bcd (
        .clk   (clk_in),
        .rst   (rst_in),
        .start (conv_start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Captured value and the force flag, which guarantees one conversion
    // after reset even when value equals the reset value of captured.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            captured   <= '0;
            force_conv <= 1'b1;
        end else if (conv_start) begin
            captured   <= value;
            force_conv <= 1'b0;
        end
    end

    // Display register: only a completed conversion updates it, so a reset
    // in the middle of a conversion never leaks a partial or stale result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            display_bcd <= '0;
        end else if (conv_done) begin
            display_bcd <= conv_bcd;
        end
    end

    // Refresh divider and digit index; each digit stays selected for DIV
    // cycles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Digit selection and optional leading-zero blanking. A blanked digit
    // still has its anode enabled; only the segment pattern goes dark.
    always_comb begin
        nibble = display_bcd[3:0];
        blank  = 1'b0;
        an_sel = 3'b001;
        case (digit_idx)
            2'd1: begin
                nibble = display_bcd[7:4];
                an_sel = 3'b010;
`ifdef SEG7_LZB_EN
                blank  = (display_bcd[11:8] == 4'd0) && (display_bcd[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                nibble = display_bcd[11:8];
                an_sel = 3'b100;
`ifdef SEG7_LZB_EN
                blank  = (display_bcd[11:8] == 4'd0);
`endif
            end
            default: begin
                nibble = display_bcd[3:0];
                an_sel = 3'b001;
            end
        endcase
        seg_hi = seg_pattern(nibble, blank);
    end

    // Registered outputs with polarity applied last; XOR with LOW inverts
    // every bit when the board drives segments and anodes low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            seg_out <= {7{LOW}};
            an_out  <= {3{LOW}};
            dp_out  <= LOW;
        end else begin
            seg_out <= seg_hi ^ {7{LOW}};
            an_out  <= an_sel ^ {3{LOW}};
            dp_out  <= ((digit_idx == '0) && carry_in) ^ LOW;
        end
    end

endmodule
